// File: rtl/status_cond_unit.sv
// NZCV status register, one-deep SPSR and ARM condition evaluation for the ID/EXE boundary.
// Flags from an S-instruction in EXE are bypassed to the ID-stage condition check in the same cycle.
module status_cond_unit #(
  parameter logic [3:0] SR_RESET = 4'b0000,
  parameter bit         NV_PASS  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] status_in,
  input  logic       ex_s_update,
  input  logic [3:0] id_cond,
  input  logic       id_valid,
  input  logic       freeze,
  input  logic       flush,
  input  logic       save_sr,
  input  logic       restore_sr,
  output logic       cin_out,
  output logic [3:0] sr_out,
  output logic [3:0] spsr_out,
  output logic       cond_pass_q,
  output logic       exe_valid_q
);

  logic [3:0] r_sr;
  logic [3:0] r_spsr;
  logic       r_cond_pass;
  logic       r_exe_valid;

  logic [3:0] w_eff;
  logic       w_n, w_z, w_c, w_v;
  logic       w_pass;

  assign w_eff = ex_s_update ? status_in : r_sr;
  assign w_n   = w_eff[3];
  assign w_z   = w_eff[2];
  assign w_c   = w_eff[1];
  assign w_v   = w_eff[0];

  always_comb begin
    w_pass = 1'b0;
    case (id_cond)
      4'b0000: w_pass = w_z;
      4'b0001: w_pass = ~w_z;
      4'b0010: w_pass = w_c;
      4'b0011: w_pass = ~w_c;
      4'b0100: w_pass = w_n;
      4'b0101: w_pass = ~w_n;
      4'b0110: w_pass = w_v;
      4'b0111: w_pass = ~w_v;
      4'b1000: w_pass = w_c & ~w_z;
      4'b1001: w_pass = ~w_c | w_z;
      4'b1010: w_pass = (w_n == w_v);
      4'b1011: w_pass = (w_n != w_v);
      4'b1100: w_pass = ~w_z & (w_n == w_v);
      4'b1101: w_pass = w_z | (w_n != w_v);
      4'b1110: w_pass = 1'b1;
      default: w_pass = NV_PASS;
    endcase
  end

  // SR ignores freeze/flush: the EXE instruction is older and always retires its flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr   <= SR_RESET;
      r_spsr <= SR_RESET;
    end else begin
      if (restore_sr)       r_sr <= r_spsr;
      else if (ex_s_update) r_sr <= status_in;

      if (save_sr && !restore_sr) r_spsr <= w_eff;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cond_pass <= 1'b0;
      r_exe_valid <= 1'b0;
    end else if (flush) begin
      r_cond_pass <= 1'b0;
      r_exe_valid <= 1'b0;
    end else if (!freeze) begin
      r_cond_pass <= w_pass;
      r_exe_valid <= id_valid & w_pass;
    end
  end

  assign sr_out      = r_sr;
  assign spsr_out    = r_spsr;
  assign cin_out     = r_sr[1];
  assign cond_pass_q = r_cond_pass;
  assign exe_valid_q = r_exe_valid;

endmodule

// File: tb/tb_status_cond_unit.sv
// Self-checking bench for status_cond_unit: directed test-plan steps plus random cycles
// compared against a flag/condition reference model built from ARM condition semantics.
module tb_status_cond_unit;

  localparam logic [3:0] SR_RESET = 4'b0000;
  localparam bit         NV_PASS  = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] status_in;
  logic       ex_s_update;
  logic [3:0] id_cond;
  logic       id_valid;
  logic       freeze;
  logic       flush;
  logic       save_sr;
  logic       restore_sr;
  logic       cin_out;
  logic [3:0] sr_out;
  logic [3:0] spsr_out;
  logic       cond_pass_q;
  logic       exe_valid_q;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic [3:0] m_sr, m_spsr;
  logic       m_cp, m_ev;

  status_cond_unit #(.SR_RESET(SR_RESET), .NV_PASS(NV_PASS)) dut (
    .clk(clk), .rst(rst), .status_in(status_in), .ex_s_update(ex_s_update),
    .id_cond(id_cond), .id_valid(id_valid), .freeze(freeze), .flush(flush),
    .save_sr(save_sr), .restore_sr(restore_sr), .cin_out(cin_out),
    .sr_out(sr_out), .spsr_out(spsr_out), .cond_pass_q(cond_pass_q),
    .exe_valid_q(exe_valid_q)
  );

  always #5 clk = ~clk;

  // ARM rule: even codes test a base predicate, odd codes test its inverse.
  function automatic bit ref_pass(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return cond[0] ? NV_PASS : 1'b1;
    endcase
    return cond[0] ? !base : base;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".sr"},   sr_out,              m_sr);
    chk({tag, ".spsr"}, spsr_out,            m_spsr);
    chk({tag, ".cin"},  {3'b000, cin_out},   {3'b000, m_sr[1]});
    chk({tag, ".cp"},   {3'b000, cond_pass_q}, {3'b000, m_cp});
    chk({tag, ".ev"},   {3'b000, exe_valid_q}, {3'b000, m_ev});
  endtask

  task automatic model_reset();
    m_sr = SR_RESET; m_spsr = SR_RESET; m_cp = 1'b0; m_ev = 1'b0;
  endtask

  // one clock with current inputs; model advanced from pre-edge state, outputs checked #1 after edge
  task automatic step(input string tag);
    logic [3:0] eff, n_sr, n_spsr;
    bit p;
    logic n_cp, n_ev;
    eff    = ex_s_update ? status_in : m_sr;
    p      = ref_pass(id_cond, eff);
    n_sr   = restore_sr ? m_spsr : (ex_s_update ? status_in : m_sr);
    n_spsr = (save_sr && !restore_sr) ? eff : m_spsr;
    n_cp = m_cp; n_ev = m_ev;
    if (flush) begin n_cp = 1'b0; n_ev = 1'b0; end
    else if (!freeze) begin n_cp = p; n_ev = id_valid && p; end
    @(posedge clk);
    #1;
    m_sr = n_sr; m_spsr = n_spsr; m_cp = n_cp; m_ev = n_ev;
    chk_all(tag);
  endtask

  task automatic idle_inputs();
    ex_s_update = 1'b0; status_in = 4'b0000; id_cond = 4'b1110; id_valid = 1'b0;
    freeze = 1'b0; flush = 1'b0; save_sr = 1'b0; restore_sr = 1'b0;
  endtask

  task automatic load_sr(input logic [3:0] val);
    idle_inputs();
    ex_s_update = 1'b1; status_in = val;
    step("load");
    ex_s_update = 1'b0;
  endtask

  initial begin
    // random inputs while reset asserted
    rst = 1'b0;
    status_in = 4'($urandom); ex_s_update = 1'b1; id_cond = 4'($urandom); id_valid = 1'b1;
    freeze = 1'b0; flush = 1'b0; save_sr = 1'b1; restore_sr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    step("post_reset");

    // update and carry
    ex_s_update = 1'b1; status_in = 4'b0010;
    step("upd");
    chk("upd.sr_const", sr_out, 4'b0010);
    chk("upd.cin_const", {3'b000, cin_out}, 4'b0001);
    ex_s_update = 1'b0; status_in = 4'b1111;
    step("upd_hold");
    chk("upd_hold.sr_const", sr_out, 4'b0010);

    // bypass: EQ sees Z from status_in in the same cycle
    load_sr(4'b0000);
    ex_s_update = 1'b1; status_in = 4'b0100; id_cond = 4'b0000; id_valid = 1'b1;
    step("bypass_eq");
    chk("bypass_eq.cp_const", {3'b000, cond_pass_q}, 4'b0001);
    chk("bypass_eq.ev_const", {3'b000, exe_valid_q}, 4'b0001);
    load_sr(4'b0000);
    ex_s_update = 1'b1; status_in = 4'b0100; id_cond = 4'b0001; id_valid = 1'b1;
    step("bypass_ne");
    chk("bypass_ne.cp_const", {3'b000, cond_pass_q}, 4'b0000);

    // full condition sweep over all SR values
    for (int s = 0; s < 16; s++) begin
      for (int c = 0; c < 16; c++) begin
        load_sr(4'(s));
        id_cond = 4'(c); id_valid = 1'b1;
        step($sformatf("sweep_sr%0h_c%0h", s, c));
      end
    end

    // freeze / flush
    load_sr(4'b0100);
    id_cond = 4'b0000; id_valid = 1'b1;
    step("fz_load");
    chk("fz_load.cp_const", {3'b000, cond_pass_q}, 4'b0001);
    freeze = 1'b1; id_cond = 4'b0001;
    step("fz_hold");
    chk("fz_hold.cp_const", {3'b000, cond_pass_q}, 4'b0001);
    ex_s_update = 1'b1; status_in = 4'b1010;
    step("fz_srupd");
    chk("fz_srupd.sr_const", sr_out, 4'b1010);
    ex_s_update = 1'b0; flush = 1'b1;
    step("fz_flush");
    chk("fz_flush.cp_const", {3'b000, cond_pass_q}, 4'b0000);
    chk("fz_flush.ev_const", {3'b000, exe_valid_q}, 4'b0000);

    // save / restore
    load_sr(4'b1001);
    save_sr = 1'b1; ex_s_update = 1'b1; status_in = 4'b0110;
    step("save");
    chk("save.spsr_const", spsr_out, 4'b0110);
    load_sr(4'b0001);
    restore_sr = 1'b1; save_sr = 1'b1; ex_s_update = 1'b1; status_in = 4'b1111;
    step("restore");
    chk("restore.sr_const", sr_out, 4'b0110);
    chk("restore.spsr_const", spsr_out, 4'b0110);

    // randomized cycles
    for (int i = 0; i < 1500; i++) begin
      status_in   = 4'($urandom);
      ex_s_update = 1'($urandom);
      id_cond     = 4'($urandom);
      id_valid    = 1'($urandom);
      freeze      = ($urandom_range(0, 5) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      save_sr     = ($urandom_range(0, 5) == 0);
      restore_sr  = ($urandom_range(0, 7) == 0);
      step($sformatf("rand%0d", i));
    end

    // asynchronous reset mid-cycle, then synchronous release
    load_sr(4'b1111);
    save_sr = 1'b1;
    step("pre_async");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    step("release");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/status_cond_unit.md
Name: status_cond_unit

Overview:
Consumer side of the ALU status interface. Holds the architectural NZCV status register and captures ALU Status_bits when an S-suffixed instruction completes EXE. Feeds the carry back to the ALU as Cin. Evaluates the 4-bit ARM condition field of the instruction in ID against forwarded flags and registers the pass/fail result into the ID/EXE boundary. Also provides a one-deep saved status register (SPSR) for exception entry and return.

Parameters:
SR_RESET, 4'b0000, reset value of SR and SPSR, ordered {N,Z,C,V}
NV_PASS, 0, result for cond 4'b1111: 0 = never execute, 1 = always execute

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
status_in  input  4  ALU Status_bits {N,Z,C,V} of the instruction in EXE
ex_s_update  input  1  EXE instruction has S set and is executing; SR write request
id_cond  input  4  condition field of the instruction in ID
id_valid  input  1  ID holds a real instruction
freeze  input  1  hazard stall; hold the ID/EXE-side registers
flush  input  1  branch taken; kill the ID/EXE-side registers
save_sr  input  1  exception entry; copy flags to SPSR
restore_sr  input  1  exception return; copy SPSR to SR
cin_out  output  1  SR.C, to ALU Cin
sr_out  output  4  current SR {N,Z,C,V}
spsr_out  output  4  current SPSR
cond_pass_q  output  1  registered condition result for the instruction now in EXE
exe_valid_q  output  1  registered id_valid & cond_pass

Behaviour:
- Reset (rst low, asynchronous): SR = SPSR = SR_RESET; cond_pass_q = 0; exe_valid_q = 0. Therefore cin_out = SR_RESET[1].
- Bit order is fixed: N=[3], Z=[2], C=[1], V=[0].
- Effective flags eff = ex_s_update ? status_in : SR. This is a combinational bypass, so an instruction in ID sees flags from the S-instruction in EXE in the same cycle.
- Condition map (pass on eff):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 NV_PASS
- SR next-state, priority high to low:
  1. restore_sr: SR <= SPSR.
  2. ex_s_update: SR <= status_in.
  3. otherwise hold.
  - SR is not gated by freeze or flush: the EXE instruction is older than the stall or branch and always retires its flags.
- SPSR next-state:
  - save_sr & !restore_sr: SPSR <= eff. The exception sees flags of the instruction completing this cycle.
  - restore_sr asserted: SPSR holds; a simultaneous save_sr is ignored.
  - otherwise hold.
- ID/EXE registers, priority high to low:
  1. flush: cond_pass_q <= 0, exe_valid_q <= 0.
  2. freeze: hold both.
  3. otherwise: cond_pass_q <= pass(id_cond, eff); exe_valid_q <= id_valid & pass.
- Latency:
  - SR visible on sr_out/cin_out one cycle after ex_s_update.
  - Condition result visible one cycle after ID presentation.
  - Bypass has zero-cycle latency.
- Back-to-back S instructions: each cycle's status_in overwrites SR; no queueing.
- id_valid = 0: cond_pass_q still reflects the evaluated condition; exe_valid_q = 0.
- Reset mid-operation: all state returns to reset values immediately, independent of clk. Release is synchronous to the next rising edge per system reset policy.
- No X propagation: with inputs known after reset, every output is known.

Test Plan:
- Reset: drive inputs random, rst low -> sr_out=0000, spsr_out=0000, cin_out=0, cond_pass_q=0, exe_valid_q=0, asynchronously.
- Update and carry: status_in=0010, ex_s_update=1 for one cycle -> next cycle sr_out=0010, cin_out=1. Then ex_s_update=0, status_in=1111 -> SR stays 0010.
- Bypass: SR=0000; same cycle ex_s_update=1, status_in=0100, id_cond=0000 (EQ), id_valid=1 -> next cycle cond_pass_q=1, exe_valid_q=1. Repeat with id_cond=0001 (NE) -> cond_pass_q=0, exe_valid_q=0.
- Condition sweep: SR forced to each of 16 values, id_cond swept 0000..1111 -> cond_pass_q matches table in all 256 cases, including GT/LE with N!=V, and NV=0 at default.
- Freeze/flush: load cond_pass_q=1; freeze=1 while id_cond changes to failing -> holds 1. freeze=1 & flush=1 -> both outputs 0. ex_s_update during freeze -> SR still updates.
- Save/restore: SR=1001; save_sr with ex_s_update=1, status_in=0110 -> SPSR=0110, SR=0110. Later SR=0001; restore_sr & save_sr & ex_s_update (status_in=1111) -> SR=0110, SPSR unchanged 0110.
